// File: rtl/mag_threshold_detector_pkg.sv
// Shared definitions for the Goertzel magnitude threshold detector:
// FSM state encoding and the default magnitude width.
package mag_threshold_detector_pkg;

  localparam int MAG_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_DET  = 2'd2,
    S_REL  = 2'd3
  } state_t;

endpackage

// File: rtl/mag_peak_hold.sv
// Peak-hold with exponential decay on each magnitude strobe, plus the
// log-scale thermometer bar derived from the updated peak.
module mag_peak_hold
  import mag_threshold_detector_pkg::*;
#(
  parameter int MAG_W       = MAG_W_DEF,
  parameter int DECAY_SHIFT = 4
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             mag_rdy,
  input  logic [MAG_W-1:0] mag_in,
  output logic [MAG_W-1:0] peak,
  output logic [7:0]       bar
);

  logic [MAG_W-1:0] peak_reg;
  logic [MAG_W-1:0] peak_next;
  logic [MAG_W-1:0] step;
  logic [7:0]       bar_reg;
  logic [7:0]       bar_next;

  always_comb begin
    step = peak_reg >> DECAY_SHIFT;
    if (step == '0) begin
      step = MAG_W'(1);
    end
    peak_next = peak_reg;
    if (mag_rdy) begin
      if (mag_in >= peak_reg) begin
        peak_next = mag_in;
      end else if (peak_reg > step) begin
        peak_next = peak_reg - step;
      end else begin
        peak_next = '0;
      end
    end
  end

  // bar[i] is set when any bit from MSB down to MAG_W-8+i of the new peak is set
  for (genvar gi = 0; gi < 8; gi++) begin : g_bar
    assign bar_next[gi] = |(peak_next >> (MAG_W - 8 + gi));
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_reg <= '0;
      bar_reg  <= '0;
    end else if (clr) begin
      peak_reg <= '0;
      bar_reg  <= '0;
    end else begin
      peak_reg <= peak_next;
      bar_reg  <= bar_next;
    end
  end

  assign peak = peak_reg;
  assign bar  = bar_reg;

endmodule

// File: rtl/mag_threshold_detector.sv
// Hysteresis tone detector with consecutive-sample debounce on Goertzel
// magnitude strobes; drives det level, rise pulse, event count and peak bar.
module mag_threshold_detector
  import mag_threshold_detector_pkg::*;
#(
  parameter int MAG_W       = MAG_W_DEF,
  parameter int N_ON        = 4,
  parameter int N_OFF       = 8,
  parameter int DECAY_SHIFT = 4
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [MAG_W-1:0] mag_in,
  input  logic             mag_rdy,
  input  logic [MAG_W-1:0] thr_on,
  input  logic [MAG_W-1:0] thr_off,
  output logic             det,
  output logic             det_rise,
  output logic [MAG_W-1:0] peak,
  output logic [7:0]       bar,
  output logic [7:0]       evt_cnt
);

  localparam logic [8:0] N_ON_C  = 9'(N_ON);
  localparam logic [8:0] N_OFF_C = 9'(N_OFF);

  state_t           state_reg, state_next;
  logic [7:0]       run_cnt_reg, run_cnt_next;
  logic             det_reg, det_next;
  logic             det_rise_reg, det_rise_next;
  logic [7:0]       evt_cnt_reg;
  logic [8:0]       run_inc;
  logic [MAG_W-1:0] thr_off_eff;
  logic             strobe;
  logic             hi;
  logic             lo;

  mag_peak_hold #(
    .MAG_W       (MAG_W),
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_peak (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .mag_rdy (mag_rdy),
    .mag_in  (mag_in),
    .peak    (peak),
    .bar     (bar)
  );

  // A release threshold above the assert threshold is clamped down to it
  assign thr_off_eff = (thr_off > thr_on) ? thr_on : thr_off;
  assign hi          = (mag_in >= thr_on);
  assign lo          = (mag_in < thr_off_eff);
  assign strobe      = mag_rdy & ~clr;
  assign run_inc     = {1'b0, run_cnt_reg} + 9'd1;

  always_comb begin
    state_next    = state_reg;
    run_cnt_next  = run_cnt_reg;
    det_rise_next = 1'b0;
    if (strobe) begin
      unique case (state_reg)
        S_IDLE: begin
          if (hi) begin
            if (N_ON == 1) begin
              state_next    = S_DET;
              run_cnt_next  = '0;
              det_rise_next = 1'b1;
            end else begin
              state_next   = S_ARM;
              run_cnt_next = 8'd1;
            end
          end
        end
        S_ARM: begin
          if (!hi) begin
            state_next   = S_IDLE;
            run_cnt_next = '0;
          end else if (run_inc >= N_ON_C) begin
            state_next    = S_DET;
            run_cnt_next  = '0;
            det_rise_next = 1'b1;
          end else begin
            run_cnt_next = run_inc[7:0];
          end
        end
        S_DET: begin
          if (lo) begin
            if (N_OFF == 1) begin
              state_next   = S_IDLE;
              run_cnt_next = '0;
            end else begin
              state_next   = S_REL;
              run_cnt_next = 8'd1;
            end
          end
        end
        S_REL: begin
          if (!lo) begin
            state_next   = S_DET;
            run_cnt_next = '0;
          end else if (run_inc >= N_OFF_C) begin
            state_next   = S_IDLE;
            run_cnt_next = '0;
          end else begin
            run_cnt_next = run_inc[7:0];
          end
        end
        default: begin
          state_next   = S_IDLE;
          run_cnt_next = '0;
        end
      endcase
    end
    det_next = (state_next == S_DET) || (state_next == S_REL);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      run_cnt_reg  <= '0;
      det_reg      <= 1'b0;
      det_rise_reg <= 1'b0;
      evt_cnt_reg  <= '0;
    end else if (clr) begin
      state_reg    <= S_IDLE;
      run_cnt_reg  <= '0;
      det_reg      <= 1'b0;
      det_rise_reg <= 1'b0;
      evt_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      run_cnt_reg  <= run_cnt_next;
      det_reg      <= det_next;
      det_rise_reg <= det_rise_next;
      evt_cnt_reg  <= evt_cnt_reg + {7'd0, det_rise_next};
    end
  end

  assign det      = det_reg;
  assign det_rise = det_rise_reg;
  assign evt_cnt  = evt_cnt_reg;

endmodule

// File: tb/tb_mag_threshold_detector.sv
// Scoreboard bench: the driver pushes model predictions per cycle, a monitor
// pops and compares one cycle later; directed scenarios then random traffic.
module tb_mag_threshold_detector;

  localparam int N_ON  = 4;
  localparam int N_OFF = 8;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        clr     = 1'b0;
  logic [15:0] mag_in  = '0;
  logic        mag_rdy = 1'b0;
  logic [15:0] thr_on_p  = 16'd1000;
  logic [15:0] thr_off_p = 16'd600;
  logic        det;
  logic        det_rise;
  logic [15:0] peak;
  logic [7:0]  bar;
  logic [7:0]  evt_cnt;

  mag_threshold_detector dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .mag_in   (mag_in),
    .mag_rdy  (mag_rdy),
    .thr_on   (thr_on_p),
    .thr_off  (thr_off_p),
    .det      (det),
    .det_rise (det_rise),
    .peak     (peak),
    .bar      (bar),
    .evt_cnt  (evt_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        det;
    logic        rise;
    logic [15:0] peak;
    logic [7:0]  bar;
    logic [7:0]  evt;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Behavioural reference: detector as a det flag with consecutive hi/lo run lengths
  int thr_on  = 1000;
  int thr_off = 600;
  int m_peak  = 0;
  bit m_det   = 0;
  int m_hi_run = 0;
  int m_lo_run = 0;
  int m_evt   = 0;

  task automatic model_reset();
    m_peak = 0; m_det = 0; m_hi_run = 0; m_lo_run = 0; m_evt = 0;
  endtask

  task automatic drive(input bit rdy, input bit c, input int mag, input int id);
    exp_t e;
    bit   rise;
    int   eff;
    int   d;
    @(negedge sys_clk);
    mag_rdy   = rdy;
    clr       = c;
    mag_in    = 16'(mag);
    thr_on_p  = 16'(thr_on);
    thr_off_p = 16'(thr_off);
    rise = 0;
    if (c) begin
      model_reset();
    end else if (rdy) begin
      if (mag >= m_peak) m_peak = mag;
      else begin
        d = m_peak / 16;
        if (d < 1) d = 1;
        m_peak = (m_peak > d) ? m_peak - d : 0;
      end
      eff = (thr_off < thr_on) ? thr_off : thr_on;
      if (!m_det) begin
        m_hi_run = (mag >= thr_on) ? m_hi_run + 1 : 0;
        if (m_hi_run >= N_ON) begin
          m_det = 1; rise = 1; m_evt = (m_evt + 1) % 256;
          m_hi_run = 0; m_lo_run = 0;
        end
      end else begin
        m_lo_run = (mag < eff) ? m_lo_run + 1 : 0;
        if (m_lo_run >= N_OFF) begin
          m_det = 0; m_hi_run = 0; m_lo_run = 0;
        end
      end
    end
    e.det  = m_det;
    e.rise = rise;
    e.peak = 16'(m_peak);
    for (int i = 0; i < 8; i++) e.bar[i] = ((m_peak >> (8 + i)) != 0);
    e.evt  = 8'(m_evt);
    e.id   = id;
    exp_q.push_back(e);
  endtask

  task automatic strobes(input int mag, input int n, input int id);
    for (int i = 0; i < n; i++) drive(1, 0, mag, id);
  endtask

  task automatic wait_drain(input int id);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge sys_clk); #2;
      k++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_t%0d: %0d expectations left, required 0", id, exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(posedge sys_clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (det !== e.det || det_rise !== e.rise || peak !== e.peak ||
          bar !== e.bar || evt_cnt !== e.evt) begin
        miscompares++;
        $display("FAIL t%0d: got det=%0b rise=%0b peak=%h bar=%h evt=%0d, required det=%0b rise=%0b peak=%h bar=%h evt=%0d",
                 e.id, det, det_rise, peak, bar, evt_cnt, e.det, e.rise, e.peak, e.bar, e.evt);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;

    // 1: async reset mid-ARM, then 3 strobes do not detect
    strobes(2000, 2, 1);
    drive(0, 0, 0, 1);
    wait_drain(1);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (det !== 1'b0 || det_rise !== 1'b0 || peak !== 16'd0 || bar !== 8'd0 || evt_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL async_reset: det=%0b rise=%0b peak=%h bar=%h evt=%0d, required all 0",
               det, det_rise, peak, bar, evt_cnt);
    end
    model_reset();
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    strobes(2000, 3, 11);
    drive(0, 0, 0, 11);

    // 2: 4 strobes assert det with a single rise pulse
    drive(0, 1, 0, 2);
    strobes(2000, 4, 2);
    drive(0, 0, 0, 2);
    drive(0, 0, 0, 2);

    // 3: hold, REL->DET re-entry, then release
    strobes(800, 20, 3);
    strobes(500, 7, 3);
    strobes(700, 1, 3);
    strobes(500, 8, 3);
    drive(0, 0, 0, 3);

    // 4: peak decay and bar
    drive(0, 1, 0, 4);
    strobes(16'hFFFF, 1, 4);
    strobes(0, 1, 4);
    drive(0, 1, 0, 4);
    strobes(3, 1, 4);
    strobes(0, 4, 4);
    drive(0, 1, 0, 4);
    strobes(16'h0100, 1, 4);

    // 5: thr_off above thr_on is clamped
    thr_off = 1200;
    drive(0, 1, 0, 5);
    strobes(2000, 4, 5);
    strobes(1100, 3, 5);
    strobes(999, 8, 5);
    thr_off = 600;

    // 6: clr beats a coincident strobe; evt_cnt wraps after 256 events
    strobes(2000, 2, 6);
    drive(1, 1, 2000, 6);
    drive(0, 0, 0, 6);
    for (int n = 0; n < 256; n++) begin
      strobes(2000, 4, 6);
      strobes(0, 8, 6);
    end
    drive(0, 0, 0, 6);

    // 7: random traffic
    drive(0, 1, 0, 7);
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        thr_on  = int'($urandom_range(200, 1500));
        thr_off = int'($urandom_range(100, 1600));
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0,
            ($urandom_range(0, 20) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 2000)),
            7);
    end
    drive(0, 0, 0, 7);
    wait_drain(7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
